// File: rtl/capture_window_scheduler.sv
// capture_window_scheduler
// Sequences ADC acquisition windows: aligns on a period trigger, skips a number
// of periods, captures for a number of periods (or until a sample cap), then
// holds the closed window until the packetizer acknowledges it.
module capture_window_scheduler #(
    parameter int CNT_WIDTH       = 32,
    parameter int PER_WIDTH       = 8,
    parameter int DEFAULT_PERIODS = 5,
    parameter int DONE_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_clear,
    input  logic                  enable,
    input  logic                  continuous,
    input  logic                  trig_sel,
    input  logic                  zcd_start,
    input  logic                  tick_60hz,
    input  logic [PER_WIDTH-1:0]  skip_periods,
    input  logic [PER_WIDTH-1:0]  save_periods,
    input  logic [CNT_WIDTH-1:0]  max_samples,
    input  logic                  sample_valid,
    input  logic                  fifo_full,
    input  logic                  pkt_ack,
    output logic                  capture_en,
    output logic                  win_sof,
    output logic                  win_eof,
    output logic [CNT_WIDTH-1:0]  win_len,
    output logic                  truncated,
    output logic                  overflow,
    output logic [DONE_WIDTH-1:0] windows_done,
    output logic [2:0]            state_o,
    output logic                  busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_SKIP    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [PER_WIDTH-1:0] per_cnt;
    logic [PER_WIDTH-1:0] skip_l;
    logic [PER_WIDTH-1:0] save_l;
    logic [CNT_WIDTH-1:0] samp_cnt;
    logic [CNT_WIDTH-1:0] max_l;
    logic                 cont_l;
    logic                 sof_seen;

    logic                 trig;
    logic                 accept;
    logic                 drop;
    logic [PER_WIDTH:0]   per_inc;
    logic [CNT_WIDTH-1:0] samp_inc;
    logic                 skip_done;
    logic                 per_close;
    logic                 cap_hit;
    logic                 win_close;
    logic                 rearm;

    // A zero period setting selects the default period count.
    function automatic logic [PER_WIDTH-1:0] eff_periods(input logic [PER_WIDTH-1:0] v);
        return (v == '0) ? PER_WIDTH'(DEFAULT_PERIODS) : v;
    endfunction

    // Trigger selection and decode of the events that move the window along
    always_comb begin
        trig      = trig_sel ? zcd_start : tick_60hz;
        accept    = sample_valid & ~fifo_full;
        drop      = sample_valid & fifo_full;
        // One extra bit so a period count of all-ones can still be matched.
        per_inc   = {1'b0, per_cnt} + (PER_WIDTH+1)'(1);
        samp_inc  = samp_cnt + CNT_WIDTH'(accept);
        skip_done = trig && (per_inc == {1'b0, skip_l});
        per_close = trig && (per_inc == {1'b0, save_l});
        cap_hit   = accept && (max_l != '0) && (samp_inc == max_l);
        win_close = per_close || cap_hit || !enable;
        rearm     = pkt_ack && cont_l && enable;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else if (soft_clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (enable) state_nxt = S_ARM;
            S_ARM: begin
                if (!enable)    state_nxt = S_IDLE;
                else if (trig)  state_nxt = S_SKIP;
            end
            S_SKIP: begin
                if (!enable)         state_nxt = S_IDLE;
                else if (skip_done)  state_nxt = S_CAPTURE;
            end
            S_CAPTURE: if (win_close) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (pkt_ack) state_nxt = rearm ? S_SKIP : S_IDLE;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Window counters, latched configuration and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_cnt      <= '0;
            samp_cnt     <= '0;
            skip_l       <= '0;
            save_l       <= '0;
            max_l        <= '0;
            cont_l       <= 1'b0;
            sof_seen     <= 1'b0;
            win_sof      <= 1'b0;
            win_eof      <= 1'b0;
            win_len      <= '0;
            truncated    <= 1'b0;
            overflow     <= 1'b0;
            windows_done <= '0;
        end else if (soft_clear) begin
            per_cnt      <= '0;
            samp_cnt     <= '0;
            skip_l       <= '0;
            save_l       <= '0;
            max_l        <= '0;
            cont_l       <= 1'b0;
            sof_seen     <= 1'b0;
            win_sof      <= 1'b0;
            win_eof      <= 1'b0;
            win_len      <= '0;
            truncated    <= 1'b0;
            overflow     <= 1'b0;
            windows_done <= '0;
        end else begin
            win_sof <= 1'b0;
            win_eof <= 1'b0;
            case (state)
                S_ARM: begin
                    // The aligning trigger is not counted as a skipped period.
                    if (enable && trig) begin
                        per_cnt <= '0;
                        skip_l  <= eff_periods(skip_periods);
                        save_l  <= eff_periods(save_periods);
                        max_l   <= max_samples;
                        cont_l  <= continuous;
                    end
                end
                S_SKIP: begin
                    if (enable && trig) begin
                        if (skip_done) begin
                            per_cnt  <= '0;
                            samp_cnt <= '0;
                            sof_seen <= 1'b0;
                        end else begin
                            per_cnt <= per_inc[PER_WIDTH-1:0];
                        end
                    end
                end
                S_CAPTURE: begin
                    samp_cnt <= samp_inc;
                    if (drop) overflow <= 1'b1;
                    if (accept && !sof_seen) begin
                        win_sof  <= 1'b1;
                        sof_seen <= 1'b1;
                    end
                    // Period close has priority over cap and abort for the
                    // truncated flag.
                    if (win_close) begin
                        win_eof   <= 1'b1;
                        win_len   <= samp_inc;
                        truncated <= !per_close;
                        per_cnt   <= '0;
                    end else if (trig) begin
                        per_cnt <= per_inc[PER_WIDTH-1:0];
                    end
                end
                S_DRAIN: begin
                    if (pkt_ack) begin
                        if (windows_done != '1) windows_done <= windows_done + DONE_WIDTH'(1);
                        // The acknowledge cycle itself is never taken as a trigger.
                        if (rearm) begin
                            per_cnt <= '0;
                            skip_l  <= eff_periods(skip_periods);
                            save_l  <= eff_periods(save_periods);
                            max_l   <= max_samples;
                            cont_l  <= continuous;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        state_o    = state;
        busy       = (state != S_IDLE);
        capture_en = (state == S_CAPTURE);
    end

endmodule

// File: tb/tb_capture_window_scheduler.sv
// tb_capture_window_scheduler
// Directed scenarios plus a randomized run against a countdown-style window
// model; every cycle the DUT outputs are compared with the model.
module tb_capture_window_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        soft_clear;
    logic        enable;
    logic        continuous;
    logic        trig_sel;
    logic        zcd_start;
    logic        tick_60hz;
    logic [7:0]  skip_periods;
    logic [7:0]  save_periods;
    logic [31:0] max_samples;
    logic        sample_valid;
    logic        fifo_full;
    logic        pkt_ack;
    logic        capture_en;
    logic        win_sof;
    logic        win_eof;
    logic [31:0] win_len;
    logic        truncated;
    logic        overflow;
    logic [15:0] windows_done;
    logic [2:0]  state_o;
    logic        busy;

    capture_window_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .soft_clear   (soft_clear),
        .enable       (enable),
        .continuous   (continuous),
        .trig_sel     (trig_sel),
        .zcd_start    (zcd_start),
        .tick_60hz    (tick_60hz),
        .skip_periods (skip_periods),
        .save_periods (save_periods),
        .max_samples  (max_samples),
        .sample_valid (sample_valid),
        .fifo_full    (fifo_full),
        .pkt_ack      (pkt_ack),
        .capture_en   (capture_en),
        .win_sof      (win_sof),
        .win_eof      (win_eof),
        .win_len      (win_len),
        .truncated    (truncated),
        .overflow     (overflow),
        .windows_done (windows_done),
        .state_o      (state_o),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Phases: 0 idle, 1 arm, 2 skip, 3 capture, 4 drain. Periods are tracked
    // as "remaining" counts taken from the effective configuration.
    int     m_phase    = 0;
    int     skip_left  = 0;
    int     save_left  = 0;
    int     m_skip_cfg = 0;
    int     m_save_cfg = 0;
    longint m_max      = 0;
    bit     m_cont     = 0;
    longint m_samples  = 0;
    bit     m_first    = 0;
    bit     m_sof      = 0;
    bit     m_eof      = 0;
    bit     m_trunc    = 0;
    bit     m_ovf      = 0;
    longint m_len      = 0;
    int     m_done     = 0;

    function automatic int eff(input int v);
        return (v == 0) ? 5 : v;
    endfunction

    task automatic model_clear();
        m_phase = 0; skip_left = 0; save_left = 0; m_skip_cfg = 0; m_save_cfg = 0;
        m_max = 0; m_cont = 0; m_samples = 0; m_first = 0; m_sof = 0; m_eof = 0;
        m_trunc = 0; m_ovf = 0; m_len = 0; m_done = 0;
    endtask

    task automatic take_cfg();
        m_skip_cfg = eff(int'(skip_periods));
        m_save_cfg = eff(int'(save_periods));
        m_max      = longint'(max_samples);
        m_cont     = continuous;
        skip_left  = m_skip_cfg;
    endtask

    task automatic model_step();
        bit t, acc, close_p, cap;
        t   = trig_sel ? zcd_start : tick_60hz;
        acc = sample_valid && !fifo_full;
        m_sof = 0;
        m_eof = 0;
        case (m_phase)
            0: if (enable) m_phase = 1;
            1: begin
                if (!enable) m_phase = 0;
                else if (t) begin take_cfg(); m_phase = 2; end
            end
            2: begin
                if (!enable) m_phase = 0;
                else if (t) begin
                    skip_left--;
                    if (skip_left == 0) begin
                        m_phase = 3; save_left = m_save_cfg; m_samples = 0; m_first = 0;
                    end
                end
            end
            3: begin
                if (sample_valid && fifo_full) m_ovf = 1;
                if (acc) begin
                    m_samples++;
                    if (!m_first) begin m_sof = 1; m_first = 1; end
                end
                close_p = t && (save_left == 1);
                cap     = acc && (m_max != 0) && (m_samples == m_max);
                if (close_p || cap || !enable) begin
                    m_eof = 1; m_len = m_samples; m_trunc = !close_p; m_phase = 4;
                end else if (t) begin
                    save_left--;
                end
            end
            4: begin
                if (pkt_ack) begin
                    if (m_done < 65535) m_done++;
                    if (m_cont && enable) begin take_cfg(); m_phase = 2; end
                    else m_phase = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst || soft_clear) model_clear();
        else model_step();
    end

    // ---------------- checking ----------------
    int     checks = 0;
    int     errors = 0;
    bit     chk_en = 0;
    string  lit_name [64];
    longint lit_act  [64];
    longint lit_exp  [64];
    int     lit_wr = 0;
    int     lit_rd = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Queue a hand-computed expectation; the compare process evaluates it.
    task automatic lit(input string name, input longint act, input longint exp);
        lit_name[lit_wr] = name;
        lit_act[lit_wr]  = act;
        lit_exp[lit_wr]  = exp;
        lit_wr++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state_o",      longint'(state_o),      longint'(m_phase));
            chk("busy",         longint'(busy),         longint'(m_phase != 0));
            chk("capture_en",   longint'(capture_en),   longint'(m_phase == 3));
            chk("win_sof",      longint'(win_sof),      longint'(m_sof));
            chk("win_eof",      longint'(win_eof),      longint'(m_eof));
            chk("win_len",      longint'(win_len),      m_len & 64'hFFFF_FFFF);
            chk("truncated",    longint'(truncated),    longint'(m_trunc));
            chk("overflow",     longint'(overflow),     longint'(m_ovf));
            chk("windows_done", longint'(windows_done), longint'(m_done));
        end
        while (lit_rd < lit_wr) begin
            chk(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
        end
    end

    // ---------------- stimulus ----------------
    int cyc_no    = 0;
    int per_len   = 100;
    bit valid_all = 1;
    int ff_left   = 0;
    bit ack_req   = 0;
    bit clr_req   = 0;
    bit rand_mode = 0;

    task automatic cyc();
        bit tk;
        @(posedge clk);
        #1;
        cyc_no++;
        tk = (per_len != 0) && (cyc_no % per_len == 0);
        if (rand_mode) begin
            tick_60hz    = ($urandom_range(0, 7) == 0);
            zcd_start    = ($urandom_range(0, 7) == 0);
            sample_valid = ($urandom_range(0, 3) != 0);
            fifo_full    = ($urandom_range(0, 9) == 0);
            pkt_ack      = ($urandom_range(0, 5) == 0);
            soft_clear   = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 59) == 0) enable = !enable;
            if ($urandom_range(0, 39) == 0) trig_sel = !trig_sel;
            continuous   = $urandom_range(0, 1) == 1;
            skip_periods = 8'($urandom_range(0, 3));
            save_periods = 8'($urandom_range(0, 3));
            max_samples  = 32'($urandom_range(0, 12));
        end else begin
            tick_60hz    = tk && !trig_sel;
            zcd_start    = tk && trig_sel;
            sample_valid = valid_all ? 1'b1 : ($urandom_range(0, 1) == 1);
            if (ff_left > 0 && sample_valid) begin
                fifo_full = 1'b1;
                ff_left--;
            end else begin
                fifo_full = 1'b0;
            end
            pkt_ack    = ack_req;
            ack_req    = 0;
            soft_clear = clr_req;
            clr_req    = 0;
        end
    endtask

    task automatic ack();
        ack_req = 1;
        cyc();
        cyc();
    endtask

    task automatic cfg(input bit ts, input int sk, input int sv, input int mx, input bit ct);
        trig_sel     = ts;
        skip_periods = 8'(sk);
        save_periods = 8'(sv);
        max_samples  = 32'(mx);
        continuous   = ct;
    endtask

    function automatic bit cond(input int what);
        case (what)
            0:       return win_eof;
            1:       return capture_en;
            2:       return state_o == 3'd2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int what, input int budget, input string name);
        int n;
        n = 0;
        while (!cond(what) && n < budget) begin
            cyc();
            n++;
        end
        if (!cond(what)) lit(name, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; soft_clear = 1'b0; enable = 1'b0; continuous = 1'b0;
        trig_sel = 1'b0; zcd_start = 1'b0; tick_60hz = 1'b0;
        skip_periods = '0; save_periods = '0; max_samples = '0;
        sample_valid = 1'b0; fifo_full = 1'b0; pkt_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1;
        lit("reset_state", state_o, 0);
        lit("reset_done", windows_done, 0);
        lit("reset_busy", busy, 0);

        // Basic tick-driven window: skip 2, save 3, period 100 -> 300 samples.
        cfg(0, 2, 3, 0, 0);
        per_len = 100;
        enable = 1;
        wait_for(0, 800, "t1_eof_timeout");
        lit("t1_win_len", win_len, 300);
        lit("t1_truncated", truncated, 0);
        enable = 0;
        repeat (3) cyc();
        ack();
        lit("t1_idle", state_o, 0);
        lit("t1_done", windows_done, 1);

        // Zero settings fall back to five periods; zero-crossing source.
        cfg(1, 0, 0, 0, 0);
        per_len = 30;
        enable = 1;
        wait_for(0, 500, "t2_eof_timeout");
        lit("t2_win_len", win_len, 150);
        enable = 0;
        ack();
        lit("t2_done", windows_done, 2);

        // Sample cap hit mid-window.
        cfg(0, 1, 3, 50, 0);
        per_len = 100;
        enable = 1;
        wait_for(0, 500, "t3a_eof_timeout");
        lit("t3a_win_len", win_len, 50);
        lit("t3a_truncated", truncated, 1);
        enable = 0;
        ack();

        // Cap reached on the very cycle of the closing trigger.
        cfg(0, 1, 3, 60, 0);
        per_len = 20;
        enable = 1;
        wait_for(0, 300, "t3b_eof_timeout");
        lit("t3b_win_len", win_len, 60);
        lit("t3b_truncated", truncated, 0);
        enable = 0;
        ack();
        lit("t3b_done", windows_done, 4);

        // Ten samples dropped to a full FIFO inside the window.
        cfg(0, 2, 3, 0, 0);
        per_len = 100;
        enable = 1;
        wait_for(1, 600, "t4_cap_timeout");
        repeat (50) cyc();
        ff_left = 10;
        wait_for(0, 600, "t4_eof_timeout");
        lit("t4_win_len", win_len, 290);
        lit("t4_overflow", overflow, 1);
        enable = 0;
        ack();
        lit("t4_overflow_sticky", overflow, 1);
        lit("t4_done", windows_done, 5);
        clr_req = 1;
        cyc();
        cyc();
        lit("t4_overflow_cleared", overflow, 0);
        lit("t4_done_cleared", windows_done, 0);

        // Continuous re-arm over three windows, then abort.
        cfg(0, 1, 1, 0, 1);
        per_len = 20;
        enable = 1;
        for (int k = 0; k < 3; k++) begin
            wait_for(0, 200, "t5_eof_timeout");
            repeat (2) cyc();
            ack();
            lit("t5_rearm_skip", state_o, 2);
        end
        lit("t5_done", windows_done, 3);
        wait_for(1, 100, "t5_cap_timeout");
        repeat (3) cyc();
        enable = 0;
        cyc();
        lit("t5_abort_eof", win_eof, 1);
        lit("t5_abort_trunc", truncated, 1);
        lit("t5_abort_drain", state_o, 4);
        repeat (5) cyc();
        ack();
        lit("t5_abort_idle", state_o, 0);
        lit("t5_abort_done", windows_done, 4);

        // Asynchronous reset in the middle of a capture.
        cfg(0, 1, 3, 0, 0);
        per_len = 50;
        enable = 1;
        wait_for(1, 200, "t6_cap_timeout");
        repeat (10) cyc();
        #2 rst = 1'b0;
        #1;
        lit("t6_rst_state", state_o, 0);
        lit("t6_rst_capen", capture_en, 0);
        lit("t6_rst_busy", busy, 0);
        lit("t6_rst_done", windows_done, 0);
        lit("t6_rst_len", win_len, 0);
        cyc();
        #2 rst = 1'b1;

        // Configuration changed during SKIP must not affect this window.
        cfg(0, 3, 2, 0, 0);
        per_len = 40;
        wait_for(2, 300, "t7_skip_timeout");
        repeat (5) cyc();
        cfg(0, 1, 5, 7, 1);
        wait_for(0, 400, "t7_eof_timeout");
        lit("t7_win_len", win_len, 80);
        lit("t7_truncated", truncated, 0);
        enable = 0;
        ack();

        // Randomized traffic checked cycle by cycle against the model.
        enable = 1;
        rand_mode = 1;
        repeat (5000) cyc();
        rand_mode = 0;
        enable = 0;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
